powerup_scheduler: RTL and testbench
====================================

# powerup_scheduler

Sequences the two map power-ups (slot 0: super speed, slot 1: fake pellet) between the two players. It detects player/power-up overlap from the player position registers and grants the power-up to one player. It then times the effect, hides the sprite, and optionally respawns it. Its outputs feed the memory-mapped power-up registers read by the processor and the sprite positions used by the VGA renderer.

## Interface
Parameters:
- `TICK_DIV`, 100000000: clock cycles per duration tick.
- `DURATION_TICKS`, 7: ticks an effect stays active.
- `RESPAWN_TICKS`, 10: ticks a slot stays hidden after its effect ends.
- `SPRITE_W`, 24: sprite width in pixels; the same for players and power-ups.
- `SPRITE_H`, 24: sprite height in pixels.
- `PU0_X`, 312 and `PU0_Y`, 325: slot 0 spawn location.
- `PU1_X`, 318 and `PU1_Y`, 163: slot 1 spawn location.
- `HIDE_XY`, 32'hFFFFFFFF: coordinate driven while a slot is not on the map.

Ports:
- `clock`, in, 1: system clock. All state changes on its falling edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `pause`, in, 1: freezes all counters and blocks pickups while high.
- `player0_x`, `player0_y`, `player1_x`, `player1_y`, in, 32 each: unsigned player positions.
- `powerup0_x`, `powerup0_y`, `powerup1_x`, `powerup1_y`, out, 32 each: current sprite positions.
- `speed_p0`, `speed_p1`, out, 1 each: slot 0 effect active for that player.
- `fake_active`, out, 1: slot 1 effect active. This flag is global.
- `fake_owner`, out, 1: player that took slot 1. Valid while `fake_active` is high.
- `pickup_evt`, out, 2: one-cycle pulse; bit n is set when slot n is picked up.

## Operation
- Each slot has its own FSM with states AVAIL, ACTIVE, COOLDOWN and SPENT, a 32-bit cycle counter `cyc` and a 32-bit tick counter `tk`.
- Overlap test for player p and slot n:
  - `px <= ux+SPRITE_W` and `px+SPRITE_W >= ux`.
  - `py <= uy+SPRITE_H` and `py+SPRITE_H >= uy`.
  - Unsigned 32-bit arithmetic. Evaluated only in AVAIL, so `HIDE_XY` wrap can never match.
- AVAIL → ACTIVE when either player overlaps and `pause`=0.
  - Player 0 has fixed priority when both players overlap in the same cycle.
  - On entry: record owner, clear `cyc`/`tk`, pulse `pickup_evt[n]`, drive the slot position to `HIDE_XY`.
- While in ACTIVE or COOLDOWN and `pause`=0:
  - `cyc` increments each cycle.
  - When `cyc==TICK_DIV-1`, `cyc` returns to 0 and `tk` increments.
- ACTIVE → COOLDOWN when the incremented `tk` reaches `DURATION_TICKS`. Counters clear and the effect flag drops.
- COOLDOWN → AVAIL when `tk` reaches `RESPAWN_TICKS`. Position returns to spawn. Without `POWERUP_RESPAWN_EN`, COOLDOWN → SPENT instead (see Configuration).
- SPENT is terminal until reset. The slot position stays at `HIDE_XY`.
- Flag outputs:
  - `speed_p0` = slot 0 ACTIVE and owner 0.
  - `speed_p1` = slot 0 ACTIVE and owner 1.
  - `fake_active` = slot 1 ACTIVE.
- Slots are independent. One player may hold both effects at once.
- A pickup while the same slot is ACTIVE is impossible, because the sprite is hidden. No restart or extension exists.
- `DURATION_TICKS`=0 or `RESPAWN_TICKS`=0 is illegal.

## Timing
- Reset values:
  - Slot positions = spawn parameters.
  - All flags, `fake_owner` and `pickup_evt` = 0.
  - FSMs in AVAIL; all counters 0.
- Reset is asynchronous: assertion mid-effect clears everything immediately. Deassertion is sampled at the next falling edge.
- All outputs are registered.
- A pickup is sampled and committed on the same falling edge. Flags, hidden position and `pickup_evt` are valid after that edge.
- ACTIVE lasts exactly `DURATION_TICKS*TICK_DIV` unpaused cycles.
- COOLDOWN lasts exactly `RESPAWN_TICKS*TICK_DIV` unpaused cycles.
- Pause cycles extend a phase one-for-one. A pickup that coincides with `pause`=1 is deferred until the first unpaused cycle in which the overlap still holds.
- `pickup_evt` is high for exactly one cycle per pickup.

## Configuration
- `POWERUP_RESPAWN_EN` defined: COOLDOWN returns the slot to AVAIL at its spawn location. Slots cycle indefinitely.
- `POWERUP_RESPAWN_EN` undefined: at the end of COOLDOWN the slot enters SPENT. Each slot is usable once per reset. The `RESPAWN_TICKS` countdown still runs before SPENT, keeping ACTIVE/COOLDOWN timing identical in both builds.

## Test plan
Bench parameters: `TICK_DIV`=4, `DURATION_TICKS`=2, `RESPAWN_TICKS`=3, macro defined unless stated.
- Reset sample: after reset, `powerup0`=(312,325), `powerup1`=(318,163) and all flags 0.
- Single pickup: player0=(300,320), player1=(0,0).
  - Next edge: `speed_p0`=1, `pickup_evt`=01, `powerup0`=(FFFFFFFF,FFFFFFFF).
  - `speed_p0` drops after 8 cycles.
  - Slot 0 reappears at (312,325) 12 cycles later.
- Simultaneous pickup: both players at (312,325) → `speed_p0`=1, `speed_p1`=0.
- Fake pellet: player1 at (330,170) → `fake_active`=1, `fake_owner`=1, `pickup_evt`=10.
- Pause mid-effect: assert `pause` for 5 cycles during slot 0 ACTIVE → `speed_p0` stays high for 13 cycles total.
- Edge overlap: player0_x=288 (=312-24) overlaps; player0_x=287 does not.
- Reset mid-operation: assert `reset`=0 during COOLDOWN → positions back to spawn with no clock edge.
- Macro undefined: after 20 cycles slot 0 stays at `HIDE_XY`; a second overlap produces no `pickup_evt`.

Source files
------------

// File: rtl/powerup_scheduler.sv
// powerup_scheduler: grants the two map power-ups (slot 0 super speed,
// slot 1 fake pellet) to whichever player overlaps them. It times the
// effect, hides the sprite during the effect and its cooldown, and then
// either respawns the slot or retires it.
// Optional feature macro: POWERUP_RESPAWN_EN. When it is defined, a slot
// returns to its spawn point after cooldown. When it is undefined, the
// slot becomes SPENT until the next reset.
// All state changes on the falling clock edge. Reset is asynchronous and
// active-low.
module powerup_scheduler #(
  parameter int unsigned TICK_DIV       = 100000000,
  parameter int unsigned DURATION_TICKS = 7,
  parameter int unsigned RESPAWN_TICKS  = 10,
  parameter int unsigned SPRITE_W       = 24,
  parameter int unsigned SPRITE_H       = 24,
  parameter int unsigned PU0_X          = 312,
  parameter int unsigned PU0_Y          = 325,
  parameter int unsigned PU1_X          = 318,
  parameter int unsigned PU1_Y          = 163,
  parameter logic [31:0] HIDE_XY        = 32'hFFFFFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pause,
  input  logic [31:0] player0_x,
  input  logic [31:0] player0_y,
  input  logic [31:0] player1_x,
  input  logic [31:0] player1_y,
  output logic [31:0] powerup0_x,
  output logic [31:0] powerup0_y,
  output logic [31:0] powerup1_x,
  output logic [31:0] powerup1_y,
  output logic        speed_p0,
  output logic        speed_p1,
  output logic        fake_active,
  output logic        fake_owner,
  output logic [1:0]  pickup_evt
);

  typedef enum logic [1:0] {
    AVAIL    = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2,
    SPENT    = 2'd3
  } state_e;

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [31:0] DUR       = 32'(DURATION_TICKS);
  localparam logic [31:0] RESP      = 32'(RESPAWN_TICKS);
  localparam logic [31:0] SPAWN_X [2] = '{32'(PU0_X), 32'(PU1_X)};
  localparam logic [31:0] SPAWN_Y [2] = '{32'(PU0_Y), 32'(PU1_Y)};

  state_e      state_q [2];
  state_e      state_d [2];
  logic [31:0] cyc_q   [2];
  logic [31:0] cyc_d   [2];
  logic [31:0] tk_q    [2];
  logic [31:0] tk_d    [2];
  logic [31:0] posx_q  [2];
  logic [31:0] posx_d  [2];
  logic [31:0] posy_q  [2];
  logic [31:0] posy_d  [2];
  logic [1:0]  owner_q;
  logic [1:0]  owner_d;
  logic [1:0]  evt_q;
  logic [1:0]  evt_d;
  logic        sp0_q, sp0_d;
  logic        sp1_q, sp1_d;
  logic        fa_q, fa_d;

  // The bounding-box test wraps at 32 bits by design. The sprite sits at
  // HIDE_XY only outside AVAIL, so that wrap can never produce a match.
  function automatic logic overlap(input logic [31:0] px, input logic [31:0] py,
                                   input logic [31:0] ux, input logic [31:0] uy);
    logic [31:0] w;
    logic [31:0] h;
    w = 32'(SPRITE_W);
    h = 32'(SPRITE_H);
    return (px <= ux + w) && (px + w >= ux) && (py <= uy + h) && (py + h >= uy);
  endfunction

  // Per-slot next state: pickup arbitration, tick timing and phase changes.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      state_d[n] = state_q[n];
      cyc_d[n]   = cyc_q[n];
      tk_d[n]    = tk_q[n];
      posx_d[n]  = posx_q[n];
      posy_d[n]  = posy_q[n];
      owner_d[n] = owner_q[n];
      evt_d[n]   = 1'b0;
      case (state_q[n])
        AVAIL: begin
          if (!pause &&
              (overlap(player0_x, player0_y, SPAWN_X[n], SPAWN_Y[n]) ||
               overlap(player1_x, player1_y, SPAWN_X[n], SPAWN_Y[n]))) begin
            state_d[n] = ACTIVE;
            // Player 0 wins ties; owner is 1 only when player 0 misses.
            owner_d[n] = !overlap(player0_x, player0_y, SPAWN_X[n], SPAWN_Y[n]);
            cyc_d[n]   = '0;
            tk_d[n]    = '0;
            evt_d[n]   = 1'b1;
            posx_d[n]  = HIDE_XY;
            posy_d[n]  = HIDE_XY;
          end
        end
        ACTIVE, COOLDOWN: begin
          if (!pause) begin
            if (cyc_q[n] == TICK_LAST) begin
              cyc_d[n] = '0;
              tk_d[n]  = tk_q[n] + 32'd1;
              if ((state_q[n] == ACTIVE) && (tk_q[n] + 32'd1 == DUR)) begin
                state_d[n] = COOLDOWN;
                tk_d[n]    = '0;
              end else if ((state_q[n] == COOLDOWN) && (tk_q[n] + 32'd1 == RESP)) begin
                tk_d[n] = '0;
`ifdef POWERUP_RESPAWN_EN
                state_d[n] = AVAIL;
                posx_d[n]  = SPAWN_X[n];
                posy_d[n]  = SPAWN_Y[n];
`else
                state_d[n] = SPENT;
`endif
              end
            end else begin
              cyc_d[n] = cyc_q[n] + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
    sp0_d = (state_d[0] == ACTIVE) && !owner_d[0];
    sp1_d = (state_d[0] == ACTIVE) &&  owner_d[0];
    fa_d  = (state_d[1] == ACTIVE);
  end

  // State, counter and output registers, cleared to spawn or idle by reset.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 2; n++) begin
        state_q[n] <= AVAIL;
        cyc_q[n]   <= '0;
        tk_q[n]    <= '0;
        posx_q[n]  <= SPAWN_X[n];
        posy_q[n]  <= SPAWN_Y[n];
      end
      owner_q <= '0;
      evt_q   <= '0;
      sp0_q   <= 1'b0;
      sp1_q   <= 1'b0;
      fa_q    <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        state_q[n] <= state_d[n];
        cyc_q[n]   <= cyc_d[n];
        tk_q[n]    <= tk_d[n];
        posx_q[n]  <= posx_d[n];
        posy_q[n]  <= posy_d[n];
      end
      owner_q <= owner_d;
      evt_q   <= evt_d;
      sp0_q   <= sp0_d;
      sp1_q   <= sp1_d;
      fa_q    <= fa_d;
    end
  end

  assign powerup0_x  = posx_q[0];
  assign powerup0_y  = posy_q[0];
  assign powerup1_x  = posx_q[1];
  assign powerup1_y  = posy_q[1];
  assign speed_p0    = sp0_q;
  assign speed_p1    = sp1_q;
  assign fake_active = fa_q;
  assign fake_owner  = owner_q[1];
  assign pickup_evt  = evt_q;

endmodule

// File: tb/tb_powerup_scheduler.sv
// Directed bench for powerup_scheduler with TICK_DIV=4, DURATION_TICKS=2
// and RESPAWN_TICKS=3. The DUT acts on falling edges. The bench drives
// inputs and samples outputs on rising edges.
module tb_powerup_scheduler;

  localparam logic [31:0] H = 32'hFFFFFFFF;

  logic        clock = 1'b0;
  logic        reset;
  logic        pause;
  logic [31:0] p0x, p0y, p1x, p1y;
  logic [31:0] pu0x, pu0y, pu1x, pu1y;
  logic        speed_p0, speed_p1, fake_active, fake_owner;
  logic [1:0]  pickup_evt;

  int checks = 0;
  int errors = 0;

  powerup_scheduler #(
    .TICK_DIV(4), .DURATION_TICKS(2), .RESPAWN_TICKS(3)
  ) dut (
    .clock(clock), .reset(reset), .pause(pause),
    .player0_x(p0x), .player0_y(p0y), .player1_x(p1x), .player1_y(p1y),
    .powerup0_x(pu0x), .powerup0_y(pu0y), .powerup1_x(pu1x), .powerup1_y(pu1y),
    .speed_p0(speed_p0), .speed_p1(speed_p1), .fake_active(fake_active),
    .fake_owner(fake_owner), .pickup_evt(pickup_evt)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] ax, ay, bx, by;
    logic        pz;
    logic [5:0]  flags;   // {speed_p0, speed_p1, fake_active, fake_owner, pickup_evt}
    logic        hid0, hid1;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {speed_p0, speed_p1, fake_active, fake_owner, pickup_evt};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic set_pos(input logic [31:0] ax, input logic [31:0] ay,
                         input logic [31:0] bx, input logic [31:0] by);
    p0x = ax; p0y = ay; p1x = bx; p1y = by;
  endtask

  // Short reset pulse that starts from a rising edge and ends before the next falling edge.
  task automatic do_reset();
    reset = 1'b0;
    pause = 1'b0;
    set_pos(0, 0, 0, 0);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{"single",   300, 320,   0,   0, 1'b0, 6'b100001, 1'b1, 1'b0};
    vecs[1]  = '{"simul",    312, 325, 312, 325, 1'b0, 6'b100001, 1'b1, 1'b0};
    vecs[2]  = '{"fake_p1",    0,   0, 330, 170, 1'b0, 6'b001110, 1'b0, 1'b1};
    vecs[3]  = '{"edge288",  288, 325,   0,   0, 1'b0, 6'b100001, 1'b1, 1'b0};
    vecs[4]  = '{"edge287",  287, 325,   0,   0, 1'b0, 6'b000000, 1'b0, 1'b0};
    vecs[5]  = '{"p1_speed",   0,   0, 312, 325, 1'b0, 6'b010001, 1'b1, 1'b0};
    vecs[6]  = '{"fake_p0",  318, 163,   0,   0, 1'b0, 6'b001010, 1'b0, 1'b1};
    vecs[7]  = '{"both",     312, 325, 318, 163, 1'b0, 6'b101111, 1'b1, 1'b1};
    vecs[8]  = '{"corner",   336, 349,   0,   0, 1'b0, 6'b100001, 1'b1, 1'b0};
    vecs[9]  = '{"right337", 337, 325,   0,   0, 1'b0, 6'b000000, 1'b0, 1'b0};
    vecs[10] = '{"top301",   312, 301,   0,   0, 1'b0, 6'b100001, 1'b1, 1'b0};
    vecs[11] = '{"top300",   312, 300,   0,   0, 1'b0, 6'b000000, 1'b0, 1'b0};
    vecs[12] = '{"paused",   300, 320,   0,   0, 1'b1, 6'b000000, 1'b0, 1'b0};

    reset = 1'b0;
    pause = 1'b0;
    set_pos(0, 0, 0, 0);
    step(2);
    reset = 1'b1;
    step(1);
    chk("reset_pu0", {pu0x, pu0y}, {32'd312, 32'd325});
    chk("reset_pu1", {pu1x, pu1y}, {32'd318, 32'd163});
    chk("reset_flags", 64'(flags()), 64'd0);

    // One-cycle pickup vectors, each from a fresh reset.
    for (int i = 0; i < 13; i++) begin
      do_reset();
      pause = vecs[i].pz;
      set_pos(vecs[i].ax, vecs[i].ay, vecs[i].bx, vecs[i].by);
      step(1);
      chk({vecs[i].name, "_flags"}, 64'(flags()), 64'(vecs[i].flags));
      chk({vecs[i].name, "_pu0"}, {pu0x, pu0y},
          vecs[i].hid0 ? {H, H} : {32'd312, 32'd325});
      chk({vecs[i].name, "_pu1"}, {pu1x, pu1y},
          vecs[i].hid1 ? {H, H} : {32'd318, 32'd163});
    end

    // Effect duration, cooldown length and end of cooldown.
    do_reset();
    set_pos(300, 320, 0, 0);
    step(1);
    chk("seq_pick", 64'(flags()), 64'b100001);
    set_pos(0, 0, 0, 0);
    step(1);
    chk("seq_evt_pulse", 64'(flags()), 64'b100000);
    step(6);
    chk("seq_sp0_at7", 64'(speed_p0), 64'd1);
    step(1);
    chk("seq_sp0_drop8", 64'(flags()), 64'd0);
    chk("seq_hidden8", {pu0x, pu0y}, {H, H});
    step(11);
    chk("seq_cool19", {pu0x, pu0y}, {H, H});
    step(1);
`ifdef POWERUP_RESPAWN_EN
    chk("seq_respawn20", {pu0x, pu0y}, {32'd312, 32'd325});
    set_pos(312, 325, 0, 0);
    step(1);
    chk("seq_repickup", 64'(flags()), 64'b100001);
`else
    chk("seq_spent20", {pu0x, pu0y}, {H, H});
    set_pos(312, 325, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("spent_no_evt", {pu0x, pu0y, 26'd0, flags()}, {H, H, 32'd0});
    end
`endif

    // Deferred pickup under pause, and a pause in the middle of the effect.
    do_reset();
    pause = 1'b1;
    set_pos(300, 320, 0, 0);
    step(2);
    chk("defer_hold", 64'(flags()), 64'd0);
    pause = 1'b0;
    step(1);
    chk("defer_pick", 64'(flags()), 64'b100001);
    set_pos(0, 0, 0, 0);
    step(2);
    pause = 1'b1;
    step(5);
    chk("pause_hold", 64'(speed_p0), 64'd1);
    pause = 1'b0;
    step(5);
    chk("pause_sp0_at12", 64'(speed_p0), 64'd1);
    step(1);
    chk("pause_sp0_at13", 64'(speed_p0), 64'd0);

    // Asynchronous reset during cooldown, with no clock edge in between.
    do_reset();
    set_pos(300, 320, 330, 170);
    step(1);
    chk("mid_pick", 64'(flags()), 64'b101111);
    set_pos(0, 0, 0, 0);
    step(10);
    chk("mid_cool_flags", 64'(flags()), 64'b000100);
    chk("mid_cool_pu0", {pu0x, pu0y}, {H, H});
    #2;
    reset = 1'b0;
    #1;
    chk("async_pu0", {pu0x, pu0y}, {32'd312, 32'd325});
    chk("async_pu1", {pu1x, pu1y}, {32'd318, 32'd163});
    chk("async_flags", 64'(flags()), 64'd0);
    reset = 1'b1;
    step(1);
    set_pos(300, 320, 0, 0);
    step(1);
    chk("after_reset_pick", 64'(flags()), 64'b100001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
